// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: control inputs, redirect targets,
// and the fetch request the sequencer presents to instruction memory.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             halt;
    logic             resume;
    logic             exception;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             pc_ready;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_step;
    logic             pc_valid;
    logic             misalign_trap;
    logic [WIDTH-1:0] bad_addr;

    // master = the sequencer, which owns the fetch request
    modport master (
        input  stall, halt, resume, exception,
        input  jump, jump_target, branch_taken, branch_target,
        input  pc_ready,
        output pc, pc_plus_step, pc_valid, misalign_trap, bad_addr
    );

    modport slave (
        output stall, halt, resume, exception,
        output jump, jump_target, branch_taken, branch_target,
        output pc_ready,
        input  pc, pc_plus_step, pc_valid, misalign_trap, bad_addr
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential advance, prioritised
// redirects, misaligned-target trapping and a BOOT/RUN/HALT control FSM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// BOOT    | one cycle after reset, no fetch request, pc stays at reset vector
// RUN     | fetch request valid, pc advances on accept or redirects
// HALT    | no fetch request, pc holds except for redirects
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int               ALIGN_BITS   = 2
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.master bus
);
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    // Zero when ALIGN_BITS is 0, which disables the alignment trap entirely.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             trap_q, trap_d;
    logic [WIDTH-1:0] bad_q, bad_d;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             target_bad;

    always_comb begin
        redirect   = bus.exception | bus.jump | bus.branch_taken;
        target     = bus.jump ? bus.jump_target : bus.branch_target;
        target_bad = |(target & ALIGN_MASK);

        state_d = state_q;
        pc_d    = pc_q;
        trap_d  = 1'b0;
        bad_d   = bad_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (bus.exception) begin
                    pc_d = EXC_VECTOR;
                end else if (bus.jump || bus.branch_taken) begin
                    if (target_bad) begin
                        pc_d   = EXC_VECTOR;
                        bad_d  = target;
                        trap_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end else if (state_q == ST_RUN && !bus.halt && bus.pc_ready && !bus.stall) begin
                    pc_d = pc_q + STEP_W;
                end

                // A redirect in RUN keeps fetching; halt only takes effect on a quiet cycle.
                if (state_q == ST_RUN) begin
                    if (bus.halt && !redirect) begin
                        state_d = ST_HALT;
                    end
                end else if (bus.resume && !bus.halt) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            trap_q  <= 1'b0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            trap_q  <= trap_d;
            bad_q   <= bad_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus_step  = pc_q + STEP_W;
    assign bus.pc_valid      = (state_q == ST_RUN);
    assign bus.misalign_trap = trap_q;
    assign bus.bad_addr      = bad_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: default build, an ALIGN_BITS=0 build
// and an 8-bit build, all sharing one clock and reset.
module tb_pc_sequencer;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pps;
        logic        valid;
        logic        trap;
        logic [31:0] bad;
    } obs_t;

    logic clk;
    logic reset;
    obs_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    pc_sequencer_if #(.WIDTH(32)) bus();
    pc_sequencer_if #(.WIDTH(32)) bus_a0();
    pc_sequencer_if #(.WIDTH(8))  bus_w8();

    pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus.master));
    pc_sequencer #(.ALIGN_BITS(0)) dut_a0 (.clk(clk), .reset(reset), .bus(bus_a0.master));
    pc_sequencer #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80), .ALIGN_BITS(2))
        dut_w8 (.clk(clk), .reset(reset), .bus(bus_w8.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [31:0] pc, input logic [31:0] pps,
                                input logic v, input logic t, input logic [31:0] bad);
        obs_t o;
        o.pc = pc; o.pps = pps; o.valid = v; o.trap = t; o.bad = bad;
        return o;
    endfunction

    function automatic obs_t smp_main();
        return mk(bus.pc, bus.pc_plus_step, bus.pc_valid, bus.misalign_trap, bus.bad_addr);
    endfunction

    function automatic obs_t smp_a0();
        return mk(bus_a0.pc, bus_a0.pc_plus_step, bus_a0.pc_valid, bus_a0.misalign_trap, bus_a0.bad_addr);
    endfunction

    function automatic obs_t smp_w8();
        return mk({24'h0, bus_w8.pc}, {24'h0, bus_w8.pc_plus_step}, bus_w8.pc_valid,
                  bus_w8.misalign_trap, {24'h0, bus_w8.bad_addr});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.stall = 0; bus.halt = 0; bus.resume = 0; bus.exception = 0;
        bus.jump = 0; bus.jump_target = '0; bus.branch_taken = 0; bus.branch_target = '0;
        bus.pc_ready = 1;
        bus_a0.stall = 0; bus_a0.halt = 0; bus_a0.resume = 0; bus_a0.exception = 0;
        bus_a0.jump = 0; bus_a0.jump_target = '0; bus_a0.branch_taken = 0; bus_a0.branch_target = '0;
        bus_a0.pc_ready = 1;
        bus_w8.stall = 0; bus_w8.halt = 0; bus_w8.resume = 0; bus_w8.exception = 0;
        bus_w8.jump = 0; bus_w8.jump_target = '0; bus_w8.branch_taken = 0; bus_w8.branch_target = '0;
        bus_w8.pc_ready = 1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        reset = 1;
        exp_q.push_back(mk(32'h0, 32'h4, 1'b0, 1'b0, 32'h0));
        tick();
        e = exp_q.pop_front(); g = smp_main(); n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL reset_boot: got pc=%h pps=%h v=%b t=%b bad=%h want pc=%h pps=%h v=%b t=%b bad=%h",
                     g.pc, g.pps, g.valid, g.trap, g.bad, e.pc, e.pps, e.valid, e.trap, e.bad);
        end
        reset = 0;
        exp_q.push_back(mk(32'h0, 32'h4, 1'b1, 1'b0, 32'h0));
        tick();
        e = exp_q.pop_front(); g = smp_main(); n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL reset_run0: got pc=%h pps=%h v=%b t=%b bad=%h want pc=%h pps=%h v=%b t=%b bad=%h",
                     g.pc, g.pps, g.valid, g.trap, g.bad, e.pc, e.pps, e.valid, e.trap, e.bad);
        end
    endtask

    task automatic test_sequential();
        obs_t e, g;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(mk(32'(4 * i), 32'(4 * i + 4), 1'b1, 1'b0, 32'h0));
            tick();
            e = exp_q.pop_front(); g = smp_main(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL sequential[%0d]: got pc=%h pps=%h v=%b want pc=%h pps=%h v=%b",
                         i, g.pc, g.pps, g.valid, e.pc, e.pps, e.valid);
            end
        end
    endtask

    task automatic test_handshake();
        obs_t e, g;
        logic        rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        stl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] pcs [4] = '{32'h10, 32'h10, 32'h10, 32'h14};
        for (int i = 0; i < 4; i++) begin
            bus.pc_ready = rdy[i]; bus.stall = stl[i];
            exp_q.push_back(mk(pcs[i], pcs[i] + 32'd4, 1'b1, 1'b0, 32'h0));
            tick();
            e = exp_q.pop_front(); g = smp_main(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL handshake[%0d]: got pc=%h v=%b want pc=%h v=%b",
                         i, g.pc, g.valid, e.pc, e.valid);
            end
        end
        bus.pc_ready = 1; bus.stall = 0;
    endtask

    task automatic test_priority();
        obs_t e, g;
        logic        exc [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        jmp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        br  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        stl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] pcs [4] = '{32'h180, 32'h400, 32'h200, 32'h204};
        bus.jump_target = 32'h400; bus.branch_target = 32'h200;
        for (int i = 0; i < 4; i++) begin
            bus.exception = exc[i]; bus.jump = jmp[i]; bus.branch_taken = br[i];
            bus.stall = stl[i]; bus.pc_ready = rdy[i];
            exp_q.push_back(mk(pcs[i], pcs[i] + 32'd4, 1'b1, 1'b0, 32'h0));
            tick();
            e = exp_q.pop_front(); g = smp_main(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL priority[%0d]: got pc=%h t=%b want pc=%h t=%b",
                         i, g.pc, g.trap, e.pc, e.trap);
            end
        end
        idle_all();
    endtask

    task automatic test_misalign();
        obs_t e, g;
        logic        jmp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        br  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] pcs [4] = '{32'h180, 32'h184, 32'h180, 32'h184};
        logic        trp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] bad [4] = '{32'h202, 32'h202, 32'h401, 32'h401};
        bus.branch_target = 32'h202; bus.jump_target = 32'h401;
        for (int i = 0; i < 4; i++) begin
            bus.jump = jmp[i]; bus.branch_taken = br[i];
            exp_q.push_back(mk(pcs[i], pcs[i] + 32'd4, 1'b1, trp[i], bad[i]));
            tick();
            e = exp_q.pop_front(); g = smp_main(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL misalign[%0d]: got pc=%h t=%b bad=%h want pc=%h t=%b bad=%h",
                         i, g.pc, g.trap, g.bad, e.pc, e.trap, e.bad);
            end
        end
        idle_all();
    endtask

    task automatic test_halt();
        obs_t e, g;
        logic        hlt [10] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        logic        res [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
        logic        jmp [10] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [31:0] tgt [10] = '{32'h20, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0};
        logic [31:0] pcs [10] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20,
                                  32'h24, 32'h24, 32'h100, 32'h100, 32'h104};
        logic        val [10] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 10; i++) begin
            bus.halt = hlt[i]; bus.resume = res[i]; bus.jump = jmp[i]; bus.jump_target = tgt[i];
            exp_q.push_back(mk(pcs[i], pcs[i] + 32'd4, val[i], 1'b0, 32'h401));
            tick();
            e = exp_q.pop_front(); g = smp_main(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL halt[%0d]: got pc=%h v=%b t=%b want pc=%h v=%b t=%b",
                         i, g.pc, g.valid, g.trap, e.pc, e.valid, e.trap);
            end
        end
        idle_all();
    endtask

    task automatic test_reset_mid();
        obs_t e, g;
        logic        rst [4] = '{0, 1, 0, 0};
        logic        jmp [4] = '{1, 1, 0, 0};
        logic [31:0] tgt [4] = '{32'h40, 32'h80, 0, 0};
        logic [31:0] pcs [4] = '{32'h40, 32'h0, 32'h0, 32'h4};
        logic        val [4] = '{1, 0, 1, 1};
        logic [31:0] bad [4] = '{32'h401, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            reset = rst[i]; bus.jump = jmp[i]; bus.jump_target = tgt[i];
            exp_q.push_back(mk(pcs[i], pcs[i] + 32'd4, val[i], 1'b0, bad[i]));
            tick();
            e = exp_q.pop_front(); g = smp_main(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL reset_mid[%0d]: got pc=%h v=%b bad=%h want pc=%h v=%b bad=%h",
                         i, g.pc, g.valid, g.bad, e.pc, e.valid, e.bad);
            end
        end
        idle_all();
    endtask

    task automatic test_align0();
        obs_t e, g;
        bus_a0.branch_target = 32'h202; bus_a0.branch_taken = 1;
        exp_q.push_back(mk(32'h202, 32'h206, 1'b1, 1'b0, 32'h0));
        tick();
        e = exp_q.pop_front(); g = smp_a0(); n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL align0_redirect: got pc=%h t=%b bad=%h want pc=%h t=%b bad=%h",
                     g.pc, g.trap, g.bad, e.pc, e.trap, e.bad);
        end
        bus_a0.branch_taken = 0;
        exp_q.push_back(mk(32'h206, 32'h20a, 1'b1, 1'b0, 32'h0));
        tick();
        e = exp_q.pop_front(); g = smp_a0(); n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL align0_advance: got pc=%h t=%b want pc=%h t=%b", g.pc, g.trap, e.pc, e.trap);
        end
    endtask

    task automatic test_wrap();
        obs_t e, g;
        logic       jmp [3] = '{1, 0, 0};
        logic [7:0] pcs [3] = '{8'hFC, 8'h00, 8'h04};
        bus_w8.jump_target = 8'hFC;
        for (int i = 0; i < 3; i++) begin
            bus_w8.jump = jmp[i];
            exp_q.push_back(mk({24'h0, pcs[i]}, {24'h0, 8'(pcs[i] + 8'd4)}, 1'b1, 1'b0, 32'h0));
            tick();
            e = exp_q.pop_front(); g = smp_w8(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got pc=%h pps=%h t=%b want pc=%h pps=%h t=%b",
                         i, g.pc, g.pps, g.trap, e.pc, e.pps, e.trap);
            end
        end
        idle_all();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1;
        idle_all();
        test_reset();
        test_sequential();
        test_handshake();
        test_priority();
        test_misalign();
        test_halt();
        test_reset_mid();
        test_align0();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS datapath fetch stage. Holds the PC register, generates the sequential next address (PC + STEP), and arbitrates exception, jump and branch redirects. It presents fetch addresses to instruction memory through a valid/ready handshake, and traps misaligned redirect targets to an exception vector.

## Interface
- WIDTH, 32, address width in bits
- STEP, 4, sequential increment in bytes; must satisfy STEP < 2^WIDTH
- RESET_VECTOR, 0, PC value after reset
- EXC_VECTOR, 32'h0000_0180, trap/exception target
- ALIGN_BITS, 2, low address bits that must be zero on any redirect target

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC; pipeline hazard stall
- halt  in  1  enter HALT state
- resume  in  1  leave HALT state
- exception  in  1  redirect to EXC_VECTOR
- jump  in  1  redirect to jump_target
- jump_target  in  WIDTH  jump address
- branch_taken  in  1  redirect to branch_target
- branch_target  in  WIDTH  branch address
- pc_ready  in  1  instruction memory accepts current pc
- pc  out  WIDTH  current fetch address (registered)
- pc_plus_step  out  WIDTH  pc + STEP, combinational, modulo 2^WIDTH (link value)
- pc_valid  out  1  pc is a valid fetch request
- misalign_trap  out  1  one-cycle pulse: misaligned redirect trapped
- bad_addr  out  WIDTH  last misaligned target captured

## Operation
- States: BOOT, RUN, HALT.
- Reset (synchronous, overrides everything): state=BOOT, pc=RESET_VECTOR, pc_valid=0, misalign_trap=0, bad_addr=0.
- BOOT: lasts exactly one cycle. pc_valid=0. Then RUN, with pc unchanged.
- RUN: pc_valid=1. The next PC is chosen by priority: exception > jump > branch_taken > sequential advance > hold.
  - exception: pc<=EXC_VECTOR. Ignores stall and pc_ready.
  - jump / branch_taken: applied regardless of stall or pc_ready. Any in-flight unaccepted request is cancelled.
  - Redirect target with target[ALIGN_BITS-1:0]!=0: pc<=EXC_VECTOR, bad_addr<=target, misalign_trap=1 for the following cycle. Not applied when ALIGN_BITS=0.
  - Sequential: pc<=pc+STEP only when pc_ready && !stall. Otherwise pc holds.
  - halt (and no redirect this cycle): go to HALT. pc holds.
- HALT: pc_valid=0. pc holds. Redirects are still applied to pc, but the state stays HALT. resume goes to RUN next cycle. If halt and resume are both asserted, halt wins.
- Arithmetic: all additions truncated to WIDTH. Wrap from 2^WIDTH-STEP to 0 is silent.
- misalign_trap is registered. It deasserts the cycle after the pulse unless another misaligned redirect occurs.

## Timing
- Latency: every input's effect on pc appears one cycle after the sampling edge. pc_plus_step follows pc combinationally.
- Handshake: a fetch transfer occurs on an edge where pc_valid && pc_ready. pc stays stable while pc_valid && !pc_ready && no redirect.
- Stall together with a redirect: the redirect wins.
- Reset mid-operation: on the next edge pc=RESET_VECTOR and state=BOOT, regardless of the other inputs.
- No combinational path from inputs to pc, pc_valid, misalign_trap or bad_addr.

## Test plan
- Reset then run with pc_ready=1 (defaults) -> pc_valid=0 for 1 cycle, then pc=0,4,8,12 on consecutive cycles; pc_plus_step=pc+4.
- Handshake/stall: pc=0x10. Drop pc_ready for 2 cycles, then assert stall for 1 cycle -> pc stays 0x10 for 3 cycles, then 0x14.
- Priority: exception, jump (0x400) and branch (0x200) asserted together -> pc=0x180. Next, jump+branch together -> pc=0x400. Branch with stall=1 and pc_ready=0 -> pc=0x200.
- Misaligned: branch_target=0x202 -> pc=0x180, bad_addr=0x202, misalign_trap high for exactly 1 cycle. With ALIGN_BITS=0 the same target gives pc=0x202.
- Wrap: WIDTH=8, STEP=4, pc=0xFC -> next pc=0x00, no flag. Halt at pc=0x20 -> pc_valid=0, pc=0x20 held. Resume -> pc_valid=1, then 0x24.
- Mid-run reset at pc=0x40 with jump asserted -> pc=RESET_VECTOR, BOOT for one cycle.
